// File: rtl/pll_ctrl_pkg.sv
// Shared definitions for the PLL lock sequencer.
//   state_t     : sequencer states
//   loop_cfg_t  : one loop-filter profile {icpsel, lpfres, lpfcap}
//   get_profile : fixed profile table, indexed 0..3
package pll_ctrl_pkg;

    typedef enum logic [2:0] {
        RST_PLL   = 3'd0,
        WAIT_LOCK = 3'd1,
        QUALIFY   = 3'd2,
        LOCKED    = 3'd3,
        FAULT     = 3'd4
    } state_t;

    typedef struct packed {
        logic [5:0] icpsel;
        logic [2:0] lpfres;
        logic [1:0] lpfcap;
    } loop_cfg_t;

    // Profiles are tried in index order; the last one is the most aggressive.
    function automatic loop_cfg_t get_profile(input logic [1:0] idx);
        loop_cfg_t cfg;
        case (idx)
            2'd0:    cfg = '{icpsel: 6'd16, lpfres: 3'd2, lpfcap: 2'd0};
            2'd1:    cfg = '{icpsel: 6'd24, lpfres: 3'd3, lpfcap: 2'd0};
            2'd2:    cfg = '{icpsel: 6'd8,  lpfres: 3'd1, lpfcap: 2'd1};
            default: cfg = '{icpsel: 6'd32, lpfres: 3'd4, lpfcap: 2'd1};
        endcase
        return cfg;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level.
//   clk   : destination clock
//   reset : synchronous, active-high; clears both flops to 0
//   d     : asynchronous input
//   q     : synchronized output, two clk cycles behind d
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    // First flop may go metastable; second flop gives it a full cycle to settle.
    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_lock_ctrl.sv
// Lock sequencer for the Ethernet clocking PLL.
// Holds the PLL in reset, applies a loop-filter profile, waits for a
// qualified lock, steps through the profile table on timeout, and recovers
// from loss of lock.
//   clkin      : 125 MHz reference
//   reset      : synchronous, active-high
//   pll_lock   : PLL lock, asynchronous to clkin
//   restart    : single-cycle pulse, restart from profile 0
//   pll_reset  : PLL reset
//   pll_icpsel, pll_lpfres, pll_lpfcap : loop-filter profile outputs
//   locked     : qualified lock (downstream reset release)
//   fault      : all profiles failed, sticky until restart/reset
//   profile    : active profile index
//   relock_cnt : saturating count of lock losses seen in LOCKED
module pll_lock_ctrl
    import pll_ctrl_pkg::*;
#(
    parameter int RST_CYCLES   = 125,
    parameter int LOCK_TIMEOUT = 125000,
    parameter int LOCK_STABLE  = 1024
) (
    input  logic       clkin,
    input  logic       reset,
    input  logic       pll_lock,
    input  logic       restart,
    output logic       pll_reset,
    output logic [5:0] pll_icpsel,
    output logic [2:0] pll_lpfres,
    output logic [1:0] pll_lpfcap,
    output logic       locked,
    output logic       fault,
    output logic [1:0] profile,
    output logic [7:0] relock_cnt
);

    localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam int TW = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
    localparam int SW = $clog2(LOCK_STABLE + 1);

    localparam logic [RW-1:0] RST_LAST    = RW'(RST_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST     = TW'(LOCK_TIMEOUT - 1);
    localparam logic [SW-1:0] STABLE_LAST = SW'(LOCK_STABLE - 1);

    logic            lock_s;
    state_t          state, state_n;
    logic [RW-1:0]   rst_cnt, rst_cnt_n;
    logic [TW-1:0]   to_cnt, to_cnt_n;
    logic [SW-1:0]   stable_cnt, stable_cnt_n;
    logic [1:0]      profile_n;
    logic [7:0]      relock_n;
    logic            locked_n, fault_n, pll_reset_n;
    loop_cfg_t       cfg, cfg_n;
    logic            timeout;

    sync_2ff u_lock_sync (
        .clk   (clkin),
        .reset (reset),
        .d     (pll_lock),
        .q     (lock_s)
    );

    assign pll_icpsel = cfg.icpsel;
    assign pll_lpfres = cfg.lpfres;
    assign pll_lpfcap = cfg.lpfcap;
    assign timeout    = (to_cnt == TO_LAST);

    // State, counters and every output are registered here.
    always_ff @(posedge clkin) begin
        if (reset) begin
            state      <= RST_PLL;
            rst_cnt    <= '0;
            to_cnt     <= '0;
            stable_cnt <= '0;
            profile    <= 2'd0;
            relock_cnt <= 8'd0;
            locked     <= 1'b0;
            fault      <= 1'b0;
            pll_reset  <= 1'b1;
            cfg        <= get_profile(2'd0);
        end else begin
            state      <= state_n;
            rst_cnt    <= rst_cnt_n;
            to_cnt     <= to_cnt_n;
            stable_cnt <= stable_cnt_n;
            profile    <= profile_n;
            relock_cnt <= relock_n;
            locked     <= locked_n;
            fault      <= fault_n;
            pll_reset  <= pll_reset_n;
            cfg        <= cfg_n;
        end
    end

    // Next-state logic. restart overrides everything; a timeout overrides
    // lock qualification so an attempt never runs past its budget.
    always_comb begin
        state_n      = state;
        rst_cnt_n    = rst_cnt;
        to_cnt_n     = to_cnt;
        stable_cnt_n = stable_cnt;
        profile_n    = profile;
        relock_n     = relock_cnt;
        locked_n     = locked;
        fault_n      = fault;

        if (restart) begin
            state_n      = RST_PLL;
            rst_cnt_n    = '0;
            to_cnt_n     = '0;
            stable_cnt_n = '0;
            profile_n    = 2'd0;
            locked_n     = 1'b0;
            fault_n      = 1'b0;
        end else begin
            case (state)
                RST_PLL: begin
                    if (rst_cnt == RST_LAST) begin
                        state_n   = WAIT_LOCK;
                        rst_cnt_n = '0;
                        to_cnt_n  = '0;
                    end else begin
                        rst_cnt_n = rst_cnt + 1'b1;
                    end
                end
                WAIT_LOCK, QUALIFY: begin
                    if (timeout) begin
                        to_cnt_n     = '0;
                        stable_cnt_n = '0;
                        rst_cnt_n    = '0;
                        if (profile == 2'd3) begin
                            state_n = FAULT;
                            fault_n = 1'b1;
                        end else begin
                            profile_n = profile + 1'b1;
                            state_n   = RST_PLL;
                        end
                    end else begin
                        to_cnt_n = to_cnt + 1'b1;
                        if (!lock_s) begin
                            state_n      = WAIT_LOCK;
                            stable_cnt_n = '0;
                        end else if (state == WAIT_LOCK && LOCK_STABLE > 1) begin
                            state_n      = QUALIFY;
                            stable_cnt_n = SW'(1);
                        end else if (state == WAIT_LOCK || stable_cnt == STABLE_LAST) begin
                            state_n      = LOCKED;
                            locked_n     = 1'b1;
                            stable_cnt_n = SW'(LOCK_STABLE);
                        end else begin
                            stable_cnt_n = stable_cnt + 1'b1;
                        end
                    end
                end
                LOCKED: begin
                    if (!lock_s) begin
                        state_n      = RST_PLL;
                        rst_cnt_n    = '0;
                        stable_cnt_n = '0;
                        locked_n     = 1'b0;
                        if (relock_cnt != 8'hFF)
                            relock_n = relock_cnt + 8'd1;
                    end
                end
                FAULT: begin
                    state_n = FAULT;
                end
                default: begin
                    state_n = RST_PLL;
                end
            endcase
        end

        // PLL reset follows the state; the loop filter is only reloaded while
        // the PLL is held in reset so it never changes under a running loop.
        pll_reset_n = (state_n == RST_PLL) || (state_n == FAULT);
        cfg_n       = cfg;
        if (pll_reset_n)
            cfg_n = get_profile(profile_n);
    end

endmodule

// File: tb/tb_pll_lock_ctrl.sv
// Directed testbench for pll_lock_ctrl with short parameters
// (RST_CYCLES=4, LOCK_TIMEOUT=64, LOCK_STABLE=8). The PLL lock input is
// driven directly by each scenario task with hand-timed waveforms.
module tb_pll_lock_ctrl;

    logic       clkin;
    logic       reset;
    logic       pll_lock;
    logic       restart;
    logic       pll_reset;
    logic [5:0] pll_icpsel;
    logic [2:0] pll_lpfres;
    logic [1:0] pll_lpfcap;
    logic       locked;
    logic       fault;
    logic [1:0] profile;
    logic [7:0] relock_cnt;

    int n_cmp = 0;
    int n_err = 0;

    pll_lock_ctrl #(
        .RST_CYCLES   (4),
        .LOCK_TIMEOUT (64),
        .LOCK_STABLE  (8)
    ) dut (
        .clkin      (clkin),
        .reset      (reset),
        .pll_lock   (pll_lock),
        .restart    (restart),
        .pll_reset  (pll_reset),
        .pll_icpsel (pll_icpsel),
        .pll_lpfres (pll_lpfres),
        .pll_lpfcap (pll_lpfcap),
        .locked     (locked),
        .fault      (fault),
        .profile    (profile),
        .relock_cnt (relock_cnt)
    );

    // 100 MHz-ish bench clock; absolute period is irrelevant to the design.
    initial clkin = 1'b0;
    always #5 clkin = ~clkin;

    // Safety net so the run can never hang.
    initial begin
        #2ms;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Advance n rising edges; inputs are driven and outputs sampled 1 time
    // unit after the edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clkin);
            #1;
        end
    endtask

    // Hold reset for 3 edges; on return no free-running edge has occurred yet.
    task automatic do_reset();
        reset    = 1'b1;
        restart  = 1'b0;
        pll_lock = 1'b0;
        tick(3);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (pll_reset !== 1'b1) begin n_err++; $display("[TB] FAIL reset_pll_reset: got %0b want 1", pll_reset); end
        n_cmp++; if (locked !== 1'b0) begin n_err++; $display("[TB] FAIL reset_locked: got %0b want 0", locked); end
        n_cmp++; if (fault !== 1'b0) begin n_err++; $display("[TB] FAIL reset_fault: got %0b want 0", fault); end
        n_cmp++; if (profile !== 2'd0) begin n_err++; $display("[TB] FAIL reset_profile: got %0d want 0", profile); end
        n_cmp++; if (relock_cnt !== 8'd0) begin n_err++; $display("[TB] FAIL reset_relock: got %0d want 0", relock_cnt); end
        n_cmp++; if ({pll_icpsel, pll_lpfres, pll_lpfcap} !== {6'd16, 3'd2, 2'd0}) begin n_err++;
            $display("[TB] FAIL reset_cfg: got %0d/%0d/%0d want 16/2/0", pll_icpsel, pll_lpfres, pll_lpfcap); end
    endtask

    task automatic test_normal_lock();
        do_reset();
        tick(3);
        n_cmp++; if (pll_reset !== 1'b1) begin n_err++; $display("[TB] FAIL norm_rst_hold: got %0b want 1", pll_reset); end
        tick(1);
        n_cmp++; if (pll_reset !== 1'b0) begin n_err++; $display("[TB] FAIL norm_rst_release: got %0b want 0", pll_reset); end
        tick(10);
        pll_lock = 1'b1;
        tick(9);
        n_cmp++; if (locked !== 1'b0) begin n_err++; $display("[TB] FAIL norm_early_lock: got %0b want 0", locked); end
        tick(1);
        n_cmp++; if (locked !== 1'b1) begin n_err++; $display("[TB] FAIL norm_locked: got %0b want 1", locked); end
        n_cmp++; if (profile !== 2'd0) begin n_err++; $display("[TB] FAIL norm_profile: got %0d want 0", profile); end
        n_cmp++; if (fault !== 1'b0) begin n_err++; $display("[TB] FAIL norm_fault: got %0b want 0", fault); end
        n_cmp++; if ({pll_icpsel, pll_lpfres, pll_lpfcap} !== {6'd16, 3'd2, 2'd0}) begin n_err++;
            $display("[TB] FAIL norm_cfg: got %0d/%0d/%0d want 16/2/0", pll_icpsel, pll_lpfres, pll_lpfcap); end
        tick(60);
        n_cmp++; if (locked !== 1'b1 || pll_reset !== 1'b0) begin n_err++;
            $display("[TB] FAIL norm_hold: got locked=%0b pll_reset=%0b want 1/0", locked, pll_reset); end
    endtask

    task automatic test_profile_step();
        do_reset();
        tick(67);
        n_cmp++; if (pll_reset !== 1'b0 || profile !== 2'd0) begin n_err++;
            $display("[TB] FAIL step_before: got pll_reset=%0b profile=%0d want 0/0", pll_reset, profile); end
        tick(1);
        n_cmp++; if (pll_reset !== 1'b1 || profile !== 2'd1) begin n_err++;
            $display("[TB] FAIL step_enter: got pll_reset=%0b profile=%0d want 1/1", pll_reset, profile); end
        n_cmp++; if ({pll_icpsel, pll_lpfres, pll_lpfcap} !== {6'd24, 3'd3, 2'd0}) begin n_err++;
            $display("[TB] FAIL step_cfg: got %0d/%0d/%0d want 24/3/0", pll_icpsel, pll_lpfres, pll_lpfcap); end
        tick(3);
        n_cmp++; if (pll_reset !== 1'b1) begin n_err++; $display("[TB] FAIL step_rst_4th: got %0b want 1", pll_reset); end
        tick(1);
        n_cmp++; if (pll_reset !== 1'b0) begin n_err++; $display("[TB] FAIL step_rst_end: got %0b want 0", pll_reset); end
        pll_lock = 1'b1;
        tick(9);
        n_cmp++; if (locked !== 1'b0) begin n_err++; $display("[TB] FAIL step_early_lock: got %0b want 0", locked); end
        tick(1);
        n_cmp++; if (locked !== 1'b1 || profile !== 2'd1) begin n_err++;
            $display("[TB] FAIL step_locked: got locked=%0b profile=%0d want 1/1", locked, profile); end
        n_cmp++; if ({pll_icpsel, pll_lpfres, pll_lpfcap} !== {6'd24, 3'd3, 2'd0}) begin n_err++;
            $display("[TB] FAIL step_cfg_hold: got %0d/%0d/%0d want 24/3/0", pll_icpsel, pll_lpfres, pll_lpfcap); end
    endtask

    task automatic test_unstable_lock();
        // Drop after 5 highs restarts qualification.
        do_reset();
        tick(4);
        pll_lock = 1'b1;
        tick(5);
        pll_lock = 1'b0;
        tick(1);
        pll_lock = 1'b1;
        tick(9);
        n_cmp++; if (locked !== 1'b0) begin n_err++; $display("[TB] FAIL unst_early_lock: got %0b want 0", locked); end
        tick(1);
        n_cmp++; if (locked !== 1'b1) begin n_err++; $display("[TB] FAIL unst_locked: got %0b want 1", locked); end
        // Late lock with a drop: the attempt budget still expires on time.
        do_reset();
        tick(54);
        pll_lock = 1'b1;
        tick(5);
        pll_lock = 1'b0;
        tick(1);
        pll_lock = 1'b1;
        tick(7);
        n_cmp++; if (pll_reset !== 1'b0 || locked !== 1'b0) begin n_err++;
            $display("[TB] FAIL unst_qualify: got pll_reset=%0b locked=%0b want 0/0", pll_reset, locked); end
        tick(1);
        n_cmp++; if (pll_reset !== 1'b1 || profile !== 2'd1 || locked !== 1'b0) begin n_err++;
            $display("[TB] FAIL unst_timeout: got pll_reset=%0b profile=%0d locked=%0b want 1/1/0", pll_reset, profile, locked); end
        pll_lock = 1'b0;
    endtask

    task automatic test_all_fail();
        do_reset();
        tick(271);
        n_cmp++; if (fault !== 1'b0 || pll_reset !== 1'b0 || profile !== 2'd3) begin n_err++;
            $display("[TB] FAIL fail_before: got fault=%0b pll_reset=%0b profile=%0d want 0/0/3", fault, pll_reset, profile); end
        tick(1);
        n_cmp++; if (fault !== 1'b1 || pll_reset !== 1'b1 || profile !== 2'd3) begin n_err++;
            $display("[TB] FAIL fail_assert: got fault=%0b pll_reset=%0b profile=%0d want 1/1/3", fault, pll_reset, profile); end
        n_cmp++; if ({pll_icpsel, pll_lpfres, pll_lpfcap} !== {6'd32, 3'd4, 2'd1}) begin n_err++;
            $display("[TB] FAIL fail_cfg: got %0d/%0d/%0d want 32/4/1", pll_icpsel, pll_lpfres, pll_lpfcap); end
        tick(20);
        n_cmp++; if (fault !== 1'b1) begin n_err++; $display("[TB] FAIL fail_sticky: got %0b want 1", fault); end
        restart = 1'b1;
        tick(1);
        restart = 1'b0;
        n_cmp++; if (fault !== 1'b0 || profile !== 2'd0 || pll_reset !== 1'b1) begin n_err++;
            $display("[TB] FAIL fail_restart: got fault=%0b profile=%0d pll_reset=%0b want 0/0/1", fault, profile, pll_reset); end
        n_cmp++; if ({pll_icpsel, pll_lpfres, pll_lpfcap} !== {6'd16, 3'd2, 2'd0}) begin n_err++;
            $display("[TB] FAIL fail_restart_cfg: got %0d/%0d/%0d want 16/2/0", pll_icpsel, pll_lpfres, pll_lpfcap); end
    endtask

    task automatic test_loss_of_lock();
        do_reset();
        tick(4);
        pll_lock = 1'b1;
        tick(10);
        n_cmp++; if (locked !== 1'b1) begin n_err++; $display("[TB] FAIL loss_initial_lock: got %0b want 1", locked); end
        pll_lock = 1'b0;
        tick(1);
        pll_lock = 1'b1;
        tick(1);
        n_cmp++; if (locked !== 1'b1) begin n_err++; $display("[TB] FAIL loss_sync_delay: got %0b want 1", locked); end
        tick(1);
        n_cmp++; if (locked !== 1'b0 || pll_reset !== 1'b1 || relock_cnt !== 8'd1 || profile !== 2'd0) begin n_err++;
            $display("[TB] FAIL loss_react: got locked=%0b pll_reset=%0b relock=%0d profile=%0d want 0/1/1/0",
                     locked, pll_reset, relock_cnt, profile); end
        tick(3);
        n_cmp++; if (pll_reset !== 1'b1) begin n_err++; $display("[TB] FAIL loss_rst_4th: got %0b want 1", pll_reset); end
        tick(1);
        n_cmp++; if (pll_reset !== 1'b0) begin n_err++; $display("[TB] FAIL loss_rst_end: got %0b want 0", pll_reset); end
        tick(7);
        n_cmp++; if (locked !== 1'b0) begin n_err++; $display("[TB] FAIL loss_early_relock: got %0b want 0", locked); end
        tick(1);
        n_cmp++; if (locked !== 1'b1) begin n_err++; $display("[TB] FAIL loss_relock: got %0b want 1", locked); end
        // Each drop: sensed 3 edges later, 4 in reset, 8 to qualify.
        for (int i = 0; i < 100; i++) begin
            pll_lock = 1'b0;
            tick(1);
            pll_lock = 1'b1;
            tick(14);
        end
        n_cmp++; if (relock_cnt !== 8'd101 || locked !== 1'b1) begin n_err++;
            $display("[TB] FAIL loss_count_101: got relock=%0d locked=%0b want 101/1", relock_cnt, locked); end
        for (int i = 0; i < 200; i++) begin
            pll_lock = 1'b0;
            tick(1);
            pll_lock = 1'b1;
            tick(14);
        end
        n_cmp++; if (relock_cnt !== 8'd255 || locked !== 1'b1) begin n_err++;
            $display("[TB] FAIL loss_saturate: got relock=%0d locked=%0b want 255/1", relock_cnt, locked); end
    endtask

    // Continues from the saturated relock count left by test_loss_of_lock.
    task automatic test_reset_mid();
        pll_lock = 1'b0;
        restart  = 1'b1;
        tick(1);
        restart = 1'b0;
        tick(150);
        n_cmp++; if (profile !== 2'd2 || pll_reset !== 1'b0 || relock_cnt !== 8'd255) begin n_err++;
            $display("[TB] FAIL mid_wait_p2: got profile=%0d pll_reset=%0b relock=%0d want 2/0/255", profile, pll_reset, relock_cnt); end
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        n_cmp++; if (pll_reset !== 1'b1 || profile !== 2'd0 || locked !== 1'b0 || fault !== 1'b0 || relock_cnt !== 8'd0) begin n_err++;
            $display("[TB] FAIL mid_reset: got pll_reset=%0b profile=%0d locked=%0b fault=%0b relock=%0d want 1/0/0/0/0",
                     pll_reset, profile, locked, fault, relock_cnt); end
        n_cmp++; if ({pll_icpsel, pll_lpfres, pll_lpfcap} !== {6'd16, 3'd2, 2'd0}) begin n_err++;
            $display("[TB] FAIL mid_reset_cfg: got %0d/%0d/%0d want 16/2/0", pll_icpsel, pll_lpfres, pll_lpfcap); end
    endtask

    task automatic test_restart_vs_loss();
        do_reset();
        tick(4);
        pll_lock = 1'b1;
        tick(10);
        n_cmp++; if (locked !== 1'b1) begin n_err++; $display("[TB] FAIL rvl_lock: got %0b want 1", locked); end
        pll_lock = 1'b0;
        tick(1);
        pll_lock = 1'b1;
        tick(1);
        // The next edge is the loss edge; restart lands on it too.
        restart = 1'b1;
        tick(1);
        restart = 1'b0;
        n_cmp++; if (relock_cnt !== 8'd0 || locked !== 1'b0 || pll_reset !== 1'b1 || profile !== 2'd0) begin n_err++;
            $display("[TB] FAIL rvl_restart_wins: got relock=%0d locked=%0b pll_reset=%0b profile=%0d want 0/0/1/0",
                     relock_cnt, locked, pll_reset, profile); end
    endtask

    initial begin
        reset    = 1'b1;
        restart  = 1'b0;
        pll_lock = 1'b0;
        test_reset();
        test_normal_lock();
        test_profile_step();
        test_unstable_lock();
        test_all_fail();
        test_loss_of_lock();
        test_reset_mid();
        test_restart_vs_loss();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
